// File: rtl/projection_calculator_pipe_if.sv
// Bus between the projection pipeline, its tracklet/projection memories and the host controller.
// Define PROJ_SATURATE_EN to add the sat_flag signal.
interface projection_calculator_pipe_if #(
  parameter int ADDR_BITS = 9,
  parameter int TRK_BITS  = 54,
  parameter int PROJ_BITS = 44
);
  logic                 start;
  logic [ADDR_BITS:0]   number_in;
  logic [ADDR_BITS-1:0] read_tracklet;
  logic [TRK_BITS-1:0]  tracklet;
  logic [ADDR_BITS-1:0] write_projection;
  logic                 wr_en;
  logic [PROJ_BITS-1:0] projection_calc;
  logic                 busy;
  logic                 done;
`ifdef PROJ_SATURATE_EN
  logic                 sat_flag;

  modport slave (
    input  start, number_in, tracklet,
    output read_tracklet, write_projection, wr_en, projection_calc, busy, done, sat_flag
  );
  modport master (
    output start, number_in, tracklet,
    input  read_tracklet, write_projection, wr_en, projection_calc, busy, done, sat_flag
  );
`else
  modport slave (
    input  start, number_in, tracklet,
    output read_tracklet, write_projection, wr_en, projection_calc, busy, done
  );
  modport master (
    output start, number_in, tracklet,
    input  read_tracklet, write_projection, wr_en, projection_calc, busy, done
  );
`endif
endinterface

// File: rtl/projection_calculator_pipe.sv
// Fixed-latency pipelined projection of tracklets to one layer radius, one event per start.
// Define PROJ_SATURATE_EN to clamp results and report clamping on sat_flag; otherwise results wrap.
module projection_calculator_pipe #(
  parameter logic [15:0] RPROJ      = 16'h86a,
  parameter int          IRINV_BITS = 14,
  parameter int          PHI_BITS   = 14,
  parameter int          Z_BITS     = 12,
  parameter int          T_BITS     = 14,
  parameter int          PHID_BITS  = 9,
  parameter int          ZD_BITS    = 9,
  parameter int          ADDR_BITS  = 9,
  parameter int          MEM_LAT    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  projection_calculator_pipe_if.slave  bus
);

  localparam int W         = 64;
  localparam int TRK_BITS  = IRINV_BITS + PHI_BITS + Z_BITS + T_BITS;
  localparam int PROJ_BITS = PHI_BITS + Z_BITS + PHID_BITS + ZD_BITS;
  localparam int LAST      = MEM_LAT + 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_BITS:0]   CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0]  ONE_S    = {{(W-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0]  RPROJ_S  = {{(W-16){1'b0}}, RPROJ};
  localparam logic signed [W-1:0]  K488     = {{(W-9){1'b0}}, 9'd488};
  localparam logic signed [W-1:0]  K_2P20   = ONE_S <<< 20;

  logic [1:0]           state_q, state_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [ADDR_BITS-1:0] read_addr_q, read_addr_d;
  logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 issue_v;
  logic                 wr_en_q;

  // vld_q[k] marks a tracklet issued k cycles ago; data leaves memory at MEM_LAT, results at LAST.
  logic [LAST:1]        vld_q;

  assign issue_v = (state_q == READ);
  assign wr_en_q = vld_q[LAST];

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    read_addr_d  = read_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    write_addr_d = wr_en_q ? write_addr_q + ADDR_ONE : write_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          write_addr_d = '0;
          if (bus.number_in != '0) begin
            count_d     = bus.number_in;
            read_addr_d = '0;
            busy_d      = 1'b1;
            state_d     = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if ({1'b0, read_addr_q} == count_q - CNT_ONE) begin
          state_d = DRAIN;
        end else begin
          read_addr_d = read_addr_q + ADDR_ONE;
        end
      end
      DRAIN: begin
        // The final tracklet is in the output register once everything upstream is empty.
        if (~|vld_q[LAST-1:1]) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      read_addr_q  <= read_addr_d;
      write_addr_q <= write_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_q[1] <= 1'b0;
    else       vld_q[1] <= issue_v;
  end

  generate
    for (genvar gi = 2; gi <= LAST; gi++) begin : g_vld
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q[gi] <= 1'b0;
        else       vld_q[gi] <= vld_q[gi-1];
      end
    end
  endgenerate

  logic signed [W-1:0] in_irinv_x, in_t_x;
  logic signed [W-1:0] out_irinv_x, out_phi0_x, out_z0_x, out_t_x;
  logic [TRK_BITS-1:0] trk_q [1:4];

  assign in_irinv_x  = {{(W-IRINV_BITS){bus.tracklet[TRK_BITS-1]}}, bus.tracklet[TRK_BITS-1 -: IRINV_BITS]};
  assign in_t_x      = {{(W-T_BITS){bus.tracklet[T_BITS-1]}}, bus.tracklet[T_BITS-1:0]};
  assign out_irinv_x = {{(W-IRINV_BITS){trk_q[4][TRK_BITS-1]}}, trk_q[4][TRK_BITS-1 -: IRINV_BITS]};
  assign out_phi0_x  = {{(W-PHI_BITS){1'b0}}, trk_q[4][Z_BITS+T_BITS +: PHI_BITS]};
  assign out_z0_x    = {{(W-Z_BITS){trk_q[4][T_BITS+Z_BITS-1]}}, trk_q[4][T_BITS +: Z_BITS]};
  assign out_t_x     = {{(W-T_BITS){trk_q[4][T_BITS-1]}}, trk_q[4][T_BITS-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) trk_q[1] <= '0;
    else       trk_q[1] <= bus.tracklet;
  end

  generate
    for (genvar gi = 2; gi <= 4; gi++) begin : g_trk
      always_ff @(posedge clk or posedge reset) begin
        if (reset) trk_q[gi] <= '0;
        else       trk_q[gi] <= trk_q[gi-1];
      end
    end
  endgenerate

  logic signed [W-1:0] it1_q, it1_s2_q, it1_s3_q;
  logic signed [W-1:0] it5_q, it5_s2_q, it5_s3_q;
  logic signed [W-1:0] it2_q, it3_q, it4_q, it6_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      it1_q    <= '0;
      it1_s2_q <= '0;
      it1_s3_q <= '0;
      it5_q    <= '0;
      it5_s2_q <= '0;
      it5_s3_q <= '0;
      it2_q    <= '0;
      it3_q    <= '0;
      it4_q    <= '0;
      it6_q    <= '0;
    end else begin
      it1_q    <= (RPROJ_S * in_irinv_x) >>> 1;
      it5_q    <= in_t_x * RPROJ_S;
      it2_q    <= (it1_q >>> 9) * (it1_q >>> 9);
      it1_s2_q <= it1_q;
      it5_s2_q <= it5_q;
      it3_q    <= K_2P20 + ((it2_q * K488) >>> 25);
      it1_s3_q <= it1_s2_q;
      it5_s3_q <= it5_s2_q;
      it4_q    <= (it1_s3_q >>> 8) * (it3_q >>> 10);
      it6_q    <= (it5_s3_q >>> 9) * (it3_q >>> 9);
    end
  end

  logic signed [W-1:0]  phi_full, z_full, phid_full, zd_full;
  logic signed [W-1:0]  phi_c, z_c, phid_c, zd_c;
  logic [PROJ_BITS-1:0] proj_d, proj_q;

  assign phi_full  = out_phi0_x - (it4_q >>> 10);
  assign z_full    = out_z0_x + (it6_q >>> 16);
  assign phid_full = -(out_irinv_x >>> 1);
  assign zd_full   = out_t_x;

`ifdef PROJ_SATURATE_EN
  localparam logic signed [W-1:0] PHI_MAX = (ONE_S <<< PHI_BITS) - ONE_S;

  function automatic logic signed [W-1:0] sclamp(input logic signed [W-1:0] v, input int bits);
    logic signed [W-1:0] hi, lo;
    hi = (ONE_S <<< (bits - 1)) - ONE_S;
    lo = -hi - ONE_S;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  logic sat_d, sat_q;

  always_comb begin
    if (phi_full[W-1])          phi_c = '0;
    else if (phi_full > PHI_MAX) phi_c = PHI_MAX;
    else                         phi_c = phi_full;
    z_c    = sclamp(z_full, Z_BITS);
    phid_c = sclamp(phid_full, PHID_BITS);
    zd_c   = sclamp(zd_full, ZD_BITS);
    sat_d  = (phi_c != phi_full) | (z_c != z_full) | (phid_c != phid_full) | (zd_c != zd_full);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sat_q <= 1'b0;
    else       sat_q <= vld_q[LAST-1] & sat_d;
  end

  assign bus.sat_flag = sat_q;
`else
  assign phi_c  = phi_full;
  assign z_c    = z_full;
  assign phid_c = phid_full;
  assign zd_c   = zd_full;
`endif

  assign proj_d = {phi_c[PHI_BITS-1:0], z_c[Z_BITS-1:0], phid_c[PHID_BITS-1:0], zd_c[ZD_BITS-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                proj_q <= '0;
    else if (vld_q[LAST-1])   proj_q <= proj_d;
  end

  assign bus.read_tracklet    = read_addr_q;
  assign bus.write_projection = write_addr_q;
  assign bus.wr_en            = wr_en_q;
  assign bus.projection_calc  = proj_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_projection_calculator_pipe.sv
// Directed bench for projection_calculator_pipe: arithmetic model plus per-cycle timing expectations.
module tb_projection_calculator_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  projection_calculator_pipe_if bus ();
  projection_calculator_pipe dut (.clk(clk), .reset(reset), .bus(bus));

  logic [53:0] tmem [0:511];
  logic [53:0] rd1, rd2;
  logic [43:0] pmem [0:511];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int ev_s     = 0;
  int ev_n     = 0;
  bit ev_on    = 1'b0;
  bit ev_abort = 1'b0;
`ifdef PROJ_SATURATE_EN
  logic sat_last = 1'b0;
`endif

  // Tracklet memory with two cycles from address to data.
  always @(posedge clk) begin
    rd1 <= tmem[bus.read_tracklet];
    rd2 <= rd1;
  end
  assign bus.tracklet = rd2;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && bus.wr_en) begin
      pmem[bus.write_projection] <= bus.projection_calc;
      wr_cnt <= wr_cnt + 1;
`ifdef PROJ_SATURATE_EN
      sat_last <= bus.sat_flag;
`endif
    end
    if (!reset && bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint fdiv(input longint a, input int k);
    longint d;
    d = longint'(1) << k;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Projection by the stated formulas with floor division standing in for arithmetic shifts.
  function automatic logic [43:0] model(input logic [53:0] trk, output bit sat);
    longint ir, ph, z0, t, t1, t2, t3, t4, t5, t6, p, z, pd, zd;
    logic [63:0] pb, zb, pdb, zdb;
    ir = longint'($signed(trk[53:40]));
    ph = longint'(trk[39:26]);
    z0 = longint'($signed(trk[25:14]));
    t  = longint'($signed(trk[13:0]));
    t1 = fdiv(2154 * ir, 1);
    t5 = t * 2154;
    t2 = fdiv(t1, 9) * fdiv(t1, 9);
    t3 = 1048576 + fdiv(t2 * 488, 25);
    t4 = fdiv(t1, 8) * fdiv(t3, 10);
    t6 = fdiv(t5, 9) * fdiv(t3, 9);
    p  = ph - fdiv(t4, 10);
    z  = z0 + fdiv(t6, 16);
    pd = -fdiv(ir, 1);
    zd = t;
    sat = 1'b0;
`ifdef PROJ_SATURATE_EN
    if (p < 0)          begin p = 0;      sat = 1'b1; end
    else if (p > 16383) begin p = 16383;  sat = 1'b1; end
    if (z < -2048)      begin z = -2048;  sat = 1'b1; end
    else if (z > 2047)  begin z = 2047;   sat = 1'b1; end
    if (pd < -256)      begin pd = -256;  sat = 1'b1; end
    else if (pd > 255)  begin pd = 255;   sat = 1'b1; end
    if (zd < -256)      begin zd = -256;  sat = 1'b1; end
    else if (zd > 255)  begin zd = 255;   sat = 1'b1; end
`endif
    pb = p; zb = z; pdb = pd; zdb = zd;
    return {pb[13:0], zb[11:0], pdb[8:0], zdb[8:0]};
  endfunction

  function automatic logic [53:0] mk(input int ir, input int ph, input int z, input int t);
    logic [31:0] a, b, c, d;
    a = ir; b = ph; c = z; d = t;
    return {a[13:0], b[13:0], c[11:0], d[13:0]};
  endfunction

  // Per-cycle checks: address k issued at start+1+k, written at start+8+k, done at start+8+n.
  always @(negedge clk) begin : cmp
    int c;
    int k;
    bit exp_wr, exp_done, exp_busy, sfl;
    logic [43:0] e;
    if (reset) begin
      chk("rst_wr_en", 64'(bus.wr_en), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_read_addr", 64'(bus.read_tracklet), 64'(0));
      chk("rst_write_addr", 64'(bus.write_projection), 64'(0));
      chk("rst_proj", 64'(bus.projection_calc), 64'(0));
`ifdef PROJ_SATURATE_EN
      chk("rst_sat", 64'(bus.sat_flag), 64'(0));
`endif
    end else if (ev_on) begin
      c = cyc - ev_s;
      if (ev_abort) begin
        chk("abort_wr_en", 64'(bus.wr_en), 64'(0));
        chk("abort_done", 64'(bus.done), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
      end else begin
        exp_wr   = (c >= 8) && (c < 8 + ev_n);
        exp_done = (ev_n == 0) ? (c == 1) : (c == 8 + ev_n);
        exp_busy = (ev_n > 0) && (c >= 1) && (c < 8 + ev_n);
        chk("wr_en", 64'(bus.wr_en), 64'(exp_wr));
        chk("done", 64'(bus.done), 64'(exp_done));
        chk("busy", 64'(bus.busy), 64'(exp_busy));
        if (ev_n > 0 && c >= 1 && c <= ev_n)
          chk("read_addr", 64'(bus.read_tracklet), 64'(c - 1));
        if (exp_wr && bus.wr_en) begin
          k = c - 8;
          e = model(tmem[k], sfl);
          chk("write_addr", 64'(bus.write_projection), 64'(k));
          chk("proj", 64'(bus.projection_calc), 64'(e));
`ifdef PROJ_SATURATE_EN
          chk("sat_flag", 64'(bus.sat_flag), 64'(sfl));
`endif
          $display("write addr=%0d proj=%011h expect=%011h", bus.write_projection, bus.projection_calc, e);
        end
      end
    end
  end

  task automatic start_event(input int n);
    @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.number_in = 10'(n);
    ev_s     = cyc;
    ev_n     = n;
    ev_on    = 1'b1;
    ev_abort = 1'b0;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.number_in = '0;
  endtask

  task automatic single(input string name, input logic [53:0] trk, input logic [43:0] lit);
    logic [43:0] m;
    bit sfl;
    tmem[0] = trk;
    start_event(1);
    repeat (12) @(posedge clk);
    m = model(trk, sfl);
    chk({name, "_model"}, 64'(m), 64'(lit));
    chk({name, "_dut"}, 64'(pmem[0]), 64'(lit));
  endtask

  initial begin : stim
    logic [43:0] lit;
    int w0, d0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.number_in = '0;
    for (int i = 0; i < 512; i++) tmem[i] = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    lit = {14'h1234, 12'h0FF, 9'h000, 9'h000};
    single("zero_curv", mk(0, 'h1234, 'h0FF, 0), lit);
    lit = {14'h0E5C, 12'h000, 9'h1CE, 9'h000};
    single("curvature", mk(100, 'h1000, 0, 0), lit);
    lit = {14'h0ABC, 12'h02A, 9'h000, 9'h0C8};
    single("zproj", mk(0, 'h0ABC, 'h010, 200), lit);
`ifdef PROJ_SATURATE_EN
    lit = {14'h0000, 12'h000, 9'h1CE, 9'h000};
`else
    lit = {14'h3F5C, 12'h000, 9'h1CE, 9'h000};
`endif
    single("underflow", mk(100, 'h0100, 0, 0), lit);
`ifdef PROJ_SATURATE_EN
    chk("underflow_sat", 64'(sat_last), 64'(1));
`endif

    // Five-tracklet stream with a start pulse that must be ignored mid-event.
    tmem[0] = mk(-300, 'h2000, -100, -500);
    tmem[1] = mk(1200, 'h0800, 50, 1000);
    tmem[2] = mk(0, 'h3FFF, 'h7FF, 8191);
    tmem[3] = mk(-8192, 'h0000, -2048, -8192);
    tmem[4] = mk(37, 'h1555, 123, -7);
    w0 = wr_cnt; d0 = done_cnt;
    start_event(5);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.number_in = 10'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.number_in = '0;
    repeat (14) @(posedge clk);
    chk("stream_writes", 64'(wr_cnt - w0), 64'(5));
    chk("stream_dones", 64'(done_cnt - d0), 64'(1));

    w0 = wr_cnt; d0 = done_cnt;
    start_event(0);
    repeat (6) @(posedge clk);
    chk("empty_writes", 64'(wr_cnt - w0), 64'(0));
    chk("empty_dones", 64'(done_cnt - d0), 64'(1));

    // Reset lands in the cycle of the third write.
    tmem[0] = mk(11, 'h0100, 1, 2);
    tmem[1] = mk(22, 'h0200, 3, 4);
    tmem[2] = mk(33, 'h0300, 5, 6);
    tmem[3] = mk(44, 'h0400, 7, 8);
    tmem[4] = mk(55, 'h0500, 9, 10);
    w0 = wr_cnt; d0 = done_cnt;
    start_event(5);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    ev_abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    chk("abort_writes", 64'(wr_cnt - w0), 64'(2));
    chk("abort_dones", 64'(done_cnt - d0), 64'(0));

    w0 = wr_cnt; d0 = done_cnt;
    start_event(3);
    repeat (14) @(posedge clk);
    chk("restart_writes", 64'(wr_cnt - w0), 64'(3));
    chk("restart_dones", 64'(done_cnt - d0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/projection_calculator_pipe.md
Name: projection_calculator_pipe

Overview:
- Parametrised successor to the single-cycle projection stub.
- Streams tracklets out of a tracklet memory.
- Runs the full integer projection algorithm (phi, z, phi-derivative, z-derivative) for one target layer radius in a fixed-latency, fully pipelined datapath.
- Writes packed projections to a projection memory under a start/busy/done handshake, once per event.

Parameters:
- RPROJ, 16'h86a, target layer radius in integer units (unsigned).
- IRINV_BITS, 14, signed rinv field width.
- PHI_BITS, 14, unsigned phi0/phiproj width.
- Z_BITS, 12, signed z0/zproj width.
- T_BITS, 14, signed tan-lambda field width.
- PHID_BITS, 9, signed phi-derivative output width.
- ZD_BITS, 9, signed z-derivative output width.
- ADDR_BITS, 9, tracklet and projection memory address width.
- MEM_LAT, 2, tracklet memory read latency in cycles (address to data).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins processing one event.
- number_in  in  ADDR_BITS+1  number of tracklets in the event (0..2^ADDR_BITS); sampled with start.
- read_tracklet  out  ADDR_BITS  tracklet memory read address.
- tracklet  in  IRINV_BITS+PHI_BITS+Z_BITS+T_BITS  read data, packed {irinv, iphi0, iz0, it}, MSB first; default 54 bits.
- write_projection  out  ADDR_BITS  projection memory write address.
- wr_en  out  1  projection write strobe.
- projection_calc  out  PHI_BITS+Z_BITS+PHID_BITS+ZD_BITS  packed {iphiproj, izproj, iphider, izder}; default 44 bits.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the event is complete.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pipeline valid bits cleared.
- Reset asserted mid-event aborts the event: no further wr_en, and no done for that event.
- FSM states:
  - IDLE: start with number_in>0 loads the count, read address = 0, go to READ. start with number_in=0 stays in IDLE, asserts no busy, and pulses done the next cycle.
  - READ: read_tracklet increments by 1 every cycle, issuing number_in consecutive addresses. After the last address, go to DRAIN.
  - DRAIN: wait until the pipeline valid chain is empty, pulse done, return to IDLE.
- start is ignored while busy.
- Pipeline:
  - Never stalls; one tracklet per cycle.
  - Total latency from address issue to wr_en is exactly MEM_LAT+5 cycles.
  - Stages (all arithmetic signed, full precision, shifts arithmetic):
    - S1: it1=(RPROJ*irinv)>>>1; it5=it*RPROJ.
    - S2: it2=(it1>>>9)*(it1>>>9).
    - S3: it3=(1<<20)+((it2*488)>>>25).
    - S4: it4=(it1>>>8)*(it3>>>10); it6=(it5>>>9)*(it3>>>9).
    - S5: iphiproj=iphi0-(it4>>>10); izproj=iz0+(it6>>>16); iphider=-(irinv>>>1); izder=it.
  - iphi0, iz0, irinv and it are delayed alongside the pipeline to S5.
- Output narrowing: results are reduced to their output widths per the optional feature.
- Write side: write_projection starts at 0 for each event and increments after each wr_en. The n-th write of an event carries the result for tracklet address n.
- done is asserted in the cycle after the final wr_en.

Optional Feature:
- Macro: PROJ_SATURATE_EN.
- Defined:
  - iphiproj is clamped to [0, 2^PHI_BITS-1].
  - izproj, iphider and izder are clamped to their signed range.
  - Any clamp sets sat_flag, an extra 1-bit output that is registered, aligned with wr_en, and reset to 0.
- Undefined: plain two's-complement truncation to the low bits; no sat_flag port.

Test Plan:
- Zero-curvature phi: irinv=0, it=0, iphi0=0x1234, iz0=0x0FF, number_in=1, start -> one wr_en at MEM_LAT+5 cycles after the address, write_projection=0, projection_calc={0x1234, 0x0FF, 0, 0}, done the following cycle.
- Curvature: irinv=100, iphi0=0x1000, it=0, iz0=0 -> iphiproj=0xE5C, izproj=0, iphider=0x1CE (-50), izder=0.
- z projection: irinv=0, it=200, iz0=0x010 -> izproj=0x02A (16+26), izder=0x0C8, iphiproj=iphi0.
- Streaming count: number_in=5 with distinct tracklets -> read_tracklet 0..4 on consecutive cycles, five back-to-back wr_en with write_projection 0..4 in order, busy high throughout, a single done; a start pulsed mid-event is ignored.
- Boundaries:
  - number_in=0 -> no read activity, no wr_en, done one cycle after start.
  - reset asserted during write 3 of 5 -> outputs 0 immediately, no further wr_en or done.
  - A new start after reset runs normally from address 0.
- Underflow: irinv=100, iphi0=0x0100 -> iphiproj=0x3F5C without PROJ_SATURATE_EN; iphiproj=0x0000 with sat_flag=1 when it is defined.
